// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - encodings shared by both ends of the serial shifter link
package shifter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  // Both link ends must agree on these so the bit order and line checking match.
  localparam int DIFF_OFF        = 0;
  localparam int DIFF_ON         = 1;
  localparam int BIT_MSB_FIRST   = 0;
  localparam int BIT_LSB_FIRST   = 1;

endpackage

// File: rtl/deshifter.sv
// rtl/deshifter.sv - serial-to-parallel receiver with held data register and valid/ready
module deshifter
  import shifter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIFFERANTIAL = DIFF_OFF,
  parameter int LSB          = BIT_MSB_FIRST
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_bit_en,
  input  logic             i_in,
  input  logic             i_negin,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_diff_err
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_overrun;
  logic             r_diff_err;
  logic             w_sample;
  logic             w_done;
  logic             w_line_bad;

  assign w_sr_next  = (LSB == BIT_LSB_FIRST) ? {i_in, r_sr[WIDTH-1:1]}
                                             : {r_sr[WIDTH-2:0], i_in};
  assign w_line_bad = (DIFFERANTIAL == DIFF_ON) && (i_in == i_negin);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // start always wins over bit_en, so a strobe coinciding with start is never sampled.
  always_comb begin
    w_state_next = r_state;
    w_sample     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = S_RECV;
      S_RECV: begin
        if (!i_start && i_bit_en) begin
          w_sample = 1'b1;
          if (r_count == LAST) begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sr       <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_diff_err <= 1'b0;
    end else begin
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (i_start) begin
        r_count <= '0;
      end else if (w_sample) begin
        r_sr    <= w_sr_next;
        r_count <= w_done ? '0 : r_count + CW'(1);
        if (w_line_bad) r_diff_err <= 1'b1;
      end
      // A word completing while the previous one is still unconsumed is dropped.
      if (w_done) begin
        if (!r_valid || i_ready) begin
          r_data  <= w_sr_next;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state == S_RECV);
  assign o_overrun  = r_overrun;
  assign o_diff_err = r_diff_err;

endmodule

// File: tb/tb_deshifter.sv
// tb/tb_deshifter.sv - directed self-checking bench for deshifter in three configurations
module tb_deshifter;
  import shifter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, bit_en, in_bit, negin, ready;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, b0, b1, b2, o0, o1, o2, e0, e1, e2;
  int         n_vec  = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  deshifter #(.WIDTH(8), .DIFFERANTIAL(DIFF_OFF), .LSB(BIT_MSB_FIRST)) u_msb (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_bit_en(bit_en), .i_in(in_bit),
    .i_negin(negin), .i_ready(ready), .o_data(d0), .o_valid(v0), .o_busy(b0),
    .o_overrun(o0), .o_diff_err(e0));

  deshifter #(.WIDTH(8), .DIFFERANTIAL(DIFF_OFF), .LSB(BIT_LSB_FIRST)) u_lsb (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_bit_en(bit_en), .i_in(in_bit),
    .i_negin(negin), .i_ready(ready), .o_data(d1), .o_valid(v1), .o_busy(b1),
    .o_overrun(o1), .o_diff_err(e1));

  deshifter #(.WIDTH(8), .DIFFERANTIAL(DIFF_ON), .LSB(BIT_MSB_FIRST)) u_dif (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_bit_en(bit_en), .i_in(in_bit),
    .i_negin(negin), .i_ready(ready), .o_data(d2), .o_valid(v2), .o_busy(b2),
    .o_overrun(o2), .o_diff_err(e2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input logic nb);
    in_bit = b;
    negin  = nb;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends w MSB first on the line; ready is raised only for the final strobe.
  task automatic send_word(input logic [7:0] w, input logic ready_last);
    do_start();
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) ready = ready_last;
      strobe(w[i], ~w[i]);
    end
    ready = 1'b0;
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bit_en = 1'b0; in_bit = 1'b0; negin = 1'b1; ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_busy", 32'(b0), 32'h0);
    chk("rst_ovr", 32'(o0), 32'h0);
    chk("rst_derr", 32'(e2), 32'h0);

    // T1: A5 MSB first; palindrome so LSB-first sees A5 too
    do_start();
    chk("t1_busy_on", 32'(b0), 32'h1);
    send_word(8'hA5, 1'b0);
    chk("t1_data_msb", 32'(d0), 32'hA5);
    chk("t1_data_lsb", 32'(d1), 32'hA5);
    chk("t1_valid", 32'(v0), 32'h1);
    chk("t1_busy_off", 32'(b0), 32'h0);
    chk("t1_derr_clean", 32'(e2), 32'h0);
    consume();
    chk("t1_valid_clr", 32'(v0), 32'h0);

    // T2: stream 1,1,0,0,0,0,0,0
    send_word(8'hC0, 1'b0);
    chk("t2_data_lsb", 32'(d1), 32'h03);
    chk("t2_data_msb", 32'(d0), 32'hC0);
    tick();
    chk("t2_valid_held", 32'(v1), 32'h1);
    consume();

    // T3: overrun then simultaneous accept
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("t3_keep_data", 32'(d0), 32'h11);
    chk("t3_valid", 32'(v0), 32'h1);
    chk("t3_overrun", 32'(o0), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_ovr_rst", 32'(o0), 32'h0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b1);
    chk("t3b_data", 32'(d0), 32'h44);
    chk("t3b_valid", 32'(v0), 32'h1);
    chk("t3b_no_ovr", 32'(o0), 32'h0);
    consume();

    // T4: restart after 3 strobes discards the partial word
    do_start();
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("t4_data", 32'(d0), 32'h3C);
    chk("t4_valid", 32'(v0), 32'h1);
    consume();

    // T7: start with bit_en in the same cycle does not sample
    start = 1'b1; bit_en = 1'b1; in_bit = 1'b1; negin = 1'b0;
    tick();
    start = 1'b0; bit_en = 1'b0;
    for (int i = 0; i < 7; i++) strobe(1'b0, 1'b1);
    chk("t7_not_done", 32'(v0), 32'h0);
    chk("t7_busy", 32'(b0), 32'h1);
    strobe(1'b0, 1'b1);
    chk("t7_data", 32'(d0), 32'h00);
    chk("t7_valid", 32'(v0), 32'h1);
    consume();

    // T5: reset mid-word, then strobes without start
    do_start();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_data", 32'(d0), 32'h0);
    chk("t5_busy", 32'(b0), 32'h0);
    chk("t5_valid", 32'(v0), 32'h0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0);
    chk("t5_idle_busy", 32'(b0), 32'h0);
    chk("t5_idle_valid", 32'(v0), 32'h0);

    // T6: 5A with negin equal to in on the 4th strobe
    do_start();
    begin
      logic [7:0] w;
      w = 8'h5A;
      for (int i = 7; i >= 0; i--) begin
        if (i == 4) strobe(w[i], w[i]);
        else        strobe(w[i], ~w[i]);
      end
    end
    chk("t6_derr", 32'(e2), 32'h1);
    chk("t6_data", 32'(d2), 32'h5A);
    chk("t6_valid", 32'(v2), 32'h1);
    chk("t6_tied0", 32'(e0), 32'h0);
    consume();
    tick();
    chk("t6_sticky", 32'(e2), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
